// File: rtl/sram_port0_arbiter.sv
// rtl/sram_port0_arbiter.sv - round-robin arbiter sharing SRAM port 0 between loader (req0) and query (req1)
// Optional post-reset zero-fill sweep enabled by defining SRAM_ARB_CLEAR_EN.
module sram_port0_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_wen,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_wen,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  addr_err,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
`ifdef SRAM_ARB_CLEAR_EN
  localparam logic [0:0] ST_RESET = ST_CLEAR;
`else
  localparam logic [0:0] ST_RESET = ST_RUN;
`endif
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [0:0]            state_q;
  logic [ADDR_WIDTH:0]   clr_cnt_q;
  logic                  init_done_q;
  logic                  rr_q;
  logic                  csb_q;
  logic                  web_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  pend0_q;
  logic                  pend1_q;
  logic                  pend_oor_q;

  logic                  grant0;
  logic                  grant1;
  logic                  acc;
  logic                  acc_wen;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_oor;
  logic                  acc_mem;

  // rr_q holds the last granted requester; a tie goes to the other one
  assign grant0 = init_done_q & req0_valid & (~req1_valid | rr_q);
  assign grant1 = init_done_q & req1_valid & (~req0_valid | ~rr_q);
  assign acc       = grant0 | grant1;
  assign acc_wen   = grant0 ? req0_wen   : req1_wen;
  assign acc_addr  = grant0 ? req0_addr  : req1_addr;
  assign acc_wdata = grant0 ? req0_wdata : req1_wdata;
  assign acc_oor   = {1'b0, acc_addr} >= DEPTH_W;
  assign acc_mem   = acc & ~acc_oor;

  assign init_done  = init_done_q;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign addr_err   = acc & acc_oor;

  // Accepted in-range transfers reach the macro combinationally; otherwise the registered view
  assign csb0  = acc_mem ? 1'b0     : csb_q;
  assign web0  = acc_mem ? ~acc_wen : web_q;
  assign addr0 = acc_mem ? acc_addr  : addr_q;
  assign din0  = acc_mem ? acc_wdata : din_q;

  assign rsp0_valid = pend0_q;
  assign rsp1_valid = pend1_q;
  assign rsp0_rdata = (pend0_q & ~pend_oor_q) ? dout0 : '0;
  assign rsp1_rdata = (pend1_q & ~pend_oor_q) ? dout0 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      rr_q        <= 1'b1;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      pend0_q     <= 1'b0;
      pend1_q     <= 1'b0;
      pend_oor_q  <= 1'b0;
    end else begin
      if (state_q == ST_CLEAR) begin
        if (clr_cnt_q < DEPTH_W) begin
          csb_q     <= 1'b0;
          web_q     <= 1'b0;
          addr_q    <= clr_cnt_q[ADDR_WIDTH-1:0];
          din_q     <= '0;
          clr_cnt_q <= clr_cnt_q + 1'b1;
        end else begin
          csb_q       <= 1'b1;
          web_q       <= 1'b1;
          state_q     <= ST_RUN;
          init_done_q <= 1'b1;
        end
      end else begin
        init_done_q <= 1'b1;
        if (acc_mem) begin
          addr_q <= acc_addr;
          din_q  <= acc_wdata;
        end
      end
      if (acc) begin
        rr_q <= grant1;
      end
      pend0_q    <= grant0 & ~req0_wen;
      pend1_q    <= grant1 & ~req1_wen;
      pend_oor_q <= acc_oor;
    end
  end

endmodule
